// File: rtl/burst_sequencer_pkg.sv
// Shared types for the DRSSTC burst sequencer: FSM states, the timing
// config record and the rule that decides whether a config may go live.
package burst_sequencer_pkg;

  // Config fields are sized for the widest supported build; narrower
  // instances zero-extend their port values into them.
  localparam int CFG_CNT_W  = 16;
  localparam int CFG_EDGE_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    RUN    = 3'd2,
    QUENCH = 3'd3,
    FAULT  = 3'd4
  } state_t;

  typedef struct packed {
    logic [CFG_CNT_W-1:0]  on_time;
    logic [CFG_CNT_W-1:0]  period;
    logic [CFG_EDGE_W-1:0] start_edges;
    logic [CFG_CNT_W-1:0]  fault_hold;
  } cfg_t;

  function automatic logic cfg_ok(input cfg_t c);
    return (c.on_time != '0) && (c.period > c.on_time) && (c.start_edges != '0);
  endfunction

endpackage

// File: rtl/burst_sequencer_tick_prescaler.sv
// Divides clk down to the timing tick; the count is held at zero while
// bursts are disarmed so the first tick after arming is a full interval.
module tick_prescaler #(
  parameter int TICK_DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  assign tick = rst_n && enable && (cnt == LAST);

endmodule

// File: rtl/burst_sequencer.sv
// Interrupter burst sequencer: generator start, hand-over to feedback after
// a number of feedback edges, quench at end of on-time, OCD lockout.
module burst_sequencer
  import burst_sequencer_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int TICK_DIV = 50,
  parameter int EDGE_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cfg_valid,
  input  logic [CNT_W-1:0]  cfg_on_time,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [EDGE_W-1:0] cfg_start_edges,
  input  logic [CNT_W-1:0]  cfg_fault_hold,
  input  logic              fb_edge,
  input  logic              ocd,
  output logic              int_out,
  output logic              sel_out,
  output logic              fault,
  output logic              cfg_err,
  output logic [7:0]        ocd_cnt,
  output logic [2:0]        state_dbg
);

  state_t            state, state_n;
  cfg_t              active, pending, cfg_in;
  logic              tick, wrap, burst_go, on_exp, edges_done, fault_done;
  logic              entering_start, entering_fault;
  logic [CNT_W-1:0]  period_cnt, on_cnt, fault_cnt;
  logic [CNT_W-1:0]  period_last, on_last, hold_last;
  logic [EDGE_W-1:0] edge_cnt;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .tick  (tick)
  );

  always_comb begin
    cfg_in             = '0;
    cfg_in.on_time     = CFG_CNT_W'(cfg_on_time);
    cfg_in.period      = CFG_CNT_W'(cfg_period);
    cfg_in.start_edges = CFG_EDGE_W'(cfg_start_edges);
    cfg_in.fault_hold  = CFG_CNT_W'(cfg_fault_hold);
  end

  // A zero period wraps on every tick, which is how the first config loads.
  assign period_last = CNT_W'(active.period) - CNT_W'(1);
  assign on_last     = CNT_W'(active.on_time) - CNT_W'(1);
  assign hold_last   = (active.fault_hold == '0) ? '0 : CNT_W'(active.fault_hold) - CNT_W'(1);

  assign wrap       = tick && ((active.period == '0) || (period_cnt == period_last));
  assign burst_go   = wrap && enable && cfg_ok(active);
  assign on_exp     = tick && (on_cnt == on_last);
  assign edges_done = fb_edge && ((edge_cnt + EDGE_W'(1)) == EDGE_W'(active.start_edges));
  assign fault_done = tick && (fault_cnt >= hold_last);

  always_comb begin
    state_n = state;
    case (state)
      IDLE, QUENCH: begin
        if (!enable)       state_n = IDLE;
        else if (burst_go) state_n = START;
      end
      START: begin
        if (ocd)             state_n = FAULT;
        else if (!enable)    state_n = IDLE;
        else if (on_exp)     state_n = QUENCH;
        else if (edges_done) state_n = RUN;
      end
      RUN: begin
        if (ocd)          state_n = FAULT;
        else if (!enable) state_n = IDLE;
        else if (on_exp)  state_n = QUENCH;
      end
      FAULT: begin
        if (fault_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign entering_start = (state_n == START) && (state != START);
  assign entering_fault = (state_n == FAULT) && (state != FAULT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // New fields only ever reach the live config at a period wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending    <= '0;
      active     <= '0;
      period_cnt <= '0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_valid) begin
        pending <= cfg_in;
      end
      if (wrap) begin
        period_cnt <= '0;
        if (cfg_ok(pending)) begin
          active <= pending;
        end else begin
          cfg_err <= 1'b1;
        end
      end else if (tick) begin
        period_cnt <= period_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      on_cnt   <= '0;
      edge_cnt <= '0;
    end else if (entering_start) begin
      on_cnt   <= '0;
      edge_cnt <= '0;
    end else if ((state == START) || (state == RUN)) begin
      if (tick) begin
        on_cnt <= on_cnt + CNT_W'(1);
      end
      if ((state == START) && fb_edge) begin
        edge_cnt <= edge_cnt + EDGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault_cnt <= '0;
      ocd_cnt   <= '0;
    end else if (entering_fault) begin
      fault_cnt <= '0;
      if (ocd_cnt != 8'hFF) begin
        ocd_cnt <= ocd_cnt + 8'd1;
      end
    end else if ((state == FAULT) && tick) begin
      fault_cnt <= fault_cnt + CNT_W'(1);
    end
  end

  assign int_out   = (state == START) || (state == RUN);
  assign sel_out   = (state == RUN);
  assign fault     = (state == FAULT);
  assign state_dbg = state;

endmodule
